// File: rtl/iterative_alu_if.sv
// Handshake/operand bundle between the EX-stage control and iterative_alu.
// The master drives requests and operands; the slave (the ALU) returns status and result.
interface iterative_alu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [3:0]      op;
    logic [XLEN-1:0] in_1;
    logic [XLEN-1:0] in_2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output start, kill, op, in_1, in_2,
        input  busy, done, result, illegal
    );

    modport slave (
        input  start, kill, op, in_1, in_2,
        output busy, done, result, illegal
    );
endinterface

// File: rtl/iterative_alu.sv
// Registered EX-stage ALU: single-cycle base integer ops plus iterative
// unsigned multiply/divide (shift-add / restoring) over one shared datapath.
// Optional feature macro: ITER_ALU_MDU_EN. When undefined, ops 1100-1111
// are reported as illegal, the iteration datapath is absent and busy is 0.
module iterative_alu #(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           reset,
    iterative_alu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;
    logic [XLEN-1:0] alu_res;
    logic            op_illegal;
    logic            op_iter;
    logic            accept;
    logic [SHW-1:0]  shamt;

    assign shamt  = bus.in_2[SHW-1:0];
    assign accept = bus.start && !bus.kill && (state != ITER);

    // Single-cycle result and op classification from the live operands
    always_comb begin
        alu_res    = '0;
        op_illegal = 1'b0;
        op_iter    = 1'b0;
        case (bus.op)
            4'b0000: alu_res = bus.in_1 + bus.in_2;
            4'b0001: alu_res = bus.in_1 - bus.in_2;
            4'b0010: alu_res = bus.in_1 << shamt;
            4'b0011: alu_res = bus.in_1 >> shamt;
            4'b0100: alu_res = $unsigned($signed(bus.in_1) >>> shamt);
            4'b0101: alu_res = bus.in_1 ^ bus.in_2;
            4'b0110: alu_res = bus.in_1 | bus.in_2;
            4'b0111: alu_res = bus.in_1 & bus.in_2;
            4'b1000: alu_res = XLEN'($signed(bus.in_1) < $signed(bus.in_2));
            4'b1001: alu_res = XLEN'(bus.in_1 < bus.in_2);
            4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
`ifdef ITER_ALU_MDU_EN
                op_iter    = 1'b1;
`else
                op_illegal = 1'b1;
`endif
            end
            default: op_illegal = 1'b1;
        endcase
    end

`ifdef ITER_ALU_MDU_EN
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd_b;
    logic [1:0]      md_op;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] md_res;

    // One iteration step: md_op[1]=0 shift-add multiply, md_op[1]=1 restoring divide
    always_comb begin
        add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_b};
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        if (!md_op[1]) begin
            {step_hi, step_lo} = {add_sum, acc_lo[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b1};
        end else begin
            step_hi = div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b0};
        end
        // MUL/DIVU take the low half (product low / quotient), MULHU/REMU the high half
        md_res = md_op[0] ? step_hi : step_lo;
    end

    // Iteration registers: operand latch on accept, then one step per ITER cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd_b <= '0;
            md_op  <= '0;
        end else if (!bus.kill) begin
            if (accept && op_iter) begin
                acc_hi <= '0;
                acc_lo <= bus.op[1] ? bus.in_1 : bus.in_2;
                opnd_b <= bus.op[1] ? bus.in_2 : bus.in_1;
                md_op  <= bus.op[1:0];
                cnt    <= SHW'(XLEN - 1);
            end else if (state == ITER) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
`endif

    // Result/illegal registers; kill leaves them untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else if (!bus.kill) begin
            if (accept) begin
                illegal_q <= op_illegal;
                if (!op_iter) begin
                    result_q <= alu_res;
                end
            end
`ifdef ITER_ALU_MDU_EN
            else if (state == ITER && cnt == '0) begin
                result_q <= md_res;
            end
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; kill overrides both start and iteration
    always_comb begin
        state_nxt = state;
        if (bus.kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_nxt = op_iter ? ITER : DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                ITER: begin
`ifdef ITER_ALU_MDU_EN
                    if (cnt == '0) begin
                        state_nxt = DONE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from state and the result registers
    always_comb begin
        bus.done    = (state == DONE);
`ifdef ITER_ALU_MDU_EN
        bus.busy    = (state == ITER);
`else
        bus.busy    = 1'b0;
`endif
        bus.result  = result_q;
        bus.illegal = illegal_q && (state == DONE);
    end
endmodule
